frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler.sv | 116 +++++++++++
 tb/tb_frame_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// Frame scheduler: counts frames at the start of vertical blanking and
// sequences NPH game-update phases inside the blanking interval.
module frame_scheduler #(
  parameter int NPH = 4,
  parameter int HD  = 640,
  parameter int VD  = 480,
  localparam int PW = (NPH > 1) ? $clog2(NPH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           p_tick,
  input  logic [9:0]     pixel_x,
  input  logic [9:0]     pixel_y,
  input  logic           enable,
  input  logic [NPH-1:0] phase_done,
  input  logic           clr_overrun,
  output logic           frame_tick,
  output logic [NPH-1:0] phase_start,
  output logic           seq_done,
  output logic           abort,
  output logic           busy,
  output logic           overrun,
  output logic [15:0]    frame_count,
  output logic [PW-1:0]  phase_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [PW-1:0]  LAST = PW'(NPH - 1);
  localparam logic [NPH-1:0] ONE  = NPH'(1);

  logic [1:0] state;
  logic       blank_start;
  logic       act_start;
  logic       cur_done;
  logic       last;

  // HD only documents the raster; line starts are keyed on pixel_x == 0
  assign blank_start = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(VD));
  assign act_start   = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign cur_done    = phase_done[phase_idx];
  assign last        = (phase_idx == LAST);

  // busy comes straight off the state flop, so it is cleared by reset at once
  assign busy = (state != IDLE);

  // Frame counter and phase sequencer; every output pulse is a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase_idx   <= '0;
      frame_count <= 16'd0;
      overrun     <= 1'b0;
      frame_tick  <= 1'b0;
      phase_start <= '0;
      seq_done    <= 1'b0;
      abort       <= 1'b0;
    end else begin
      frame_tick  <= 1'b0;
      phase_start <= '0;
      seq_done    <= 1'b0;
      abort       <= 1'b0;

      if (blank_start) begin
        frame_tick  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end

      if (clr_overrun)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (blank_start && enable) begin
            state     <= ISSUE;
            phase_idx <= '0;
          end
        end
        ISSUE: begin
          if (act_start) begin
            state     <= IDLE;
            phase_idx <= '0;
            abort     <= 1'b1;
            overrun   <= 1'b1;
          end else begin
            phase_start <= ONE << phase_idx;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // a last-phase completion beats a coincident active-video start
          if (cur_done && last) begin
            state     <= IDLE;
            phase_idx <= '0;
            seq_done  <= 1'b1;
          end else if (act_start) begin
            state     <= IDLE;
            phase_idx <= '0;
            abort     <= 1'b1;
            overrun   <= 1'b1;
          end else if (cur_done) begin
            phase_idx <= phase_idx + PW'(1);
            state     <= ISSUE;
          end
        end
        default: begin
          state     <= IDLE;
          phase_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: inputs change 1 ns after a rising
// edge, outputs are checked there, well away from the next edge.
module tb_frame_scheduler;

  localparam int NPH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           p_tick;
  logic [9:0]     pixel_x;
  logic [9:0]     pixel_y;
  logic           enable;
  logic [NPH-1:0] phase_done;
  logic           clr_overrun;
  logic           frame_tick;
  logic [NPH-1:0] phase_start;
  logic           seq_done;
  logic           abort;
  logic           busy;
  logic           overrun;
  logic [15:0]    frame_count;
  logic [1:0]     phase_idx;

  int n_chk  = 0;
  int n_fail = 0;

  frame_scheduler #(.NPH(NPH), .HD(640), .VD(480)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_tick      (p_tick),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .enable      (enable),
    .phase_done  (phase_done),
    .clr_overrun (clr_overrun),
    .frame_tick  (frame_tick),
    .phase_start (phase_start),
    .seq_done    (seq_done),
    .abort       (abort),
    .busy        (busy),
    .overrun     (overrun),
    .frame_count (frame_count),
    .phase_idx   (phase_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic blank();
    p_tick  = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd480;
    cyc();
    p_tick  = 1'b0;
    pixel_y = 10'd100;
  endtask

  task automatic act();
    p_tick  = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    cyc();
    p_tick  = 1'b0;
    pixel_y = 10'd100;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Start a frame and complete phases 0..n-1, each done 3 clk after its
  // start. With n < NPH it returns in WAIT for phase n.
  task automatic run_frame(input int n, input logic [15:0] fc,
                           input logic ov);
    blank();
    chk("ftick", 32'(frame_tick), 32'd1);
    chk("fcount", 32'(frame_count), 32'(fc));
    chk("busy_on", 32'(busy), 32'd1);
    cyc();
    for (int i = 0; i < NPH; i++) begin
      chk("pstart", 32'(phase_start), 32'd1 << i);
      chk("pidx", 32'(phase_idx), 32'(i));
      if (i == n) return;
      cyc();
      cyc();
      phase_done = NPH'(1) << i;
      cyc();
      phase_done = '0;
      if (i == NPH - 1) begin
        chk("seq_done", 32'(seq_done), 32'd1);
        chk("busy_off", 32'(busy), 32'd0);
        chk("no_abort", 32'(abort), 32'd0);
        chk("ovr", 32'(overrun), 32'(ov));
        cyc();
        chk("seq_done_1clk", 32'(seq_done), 32'd0);
      end else begin
        chk("busy_mid", 32'(busy), 32'd1);
        chk("no_seq_done", 32'(seq_done), 32'd0);
        cyc();
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    p_tick      = 1'b0;
    pixel_x     = 10'd5;
    pixel_y     = 10'd100;
    enable      = 1'b1;
    phase_done  = '0;
    clr_overrun = 1'b0;
    #3;
    chk("rst_fcount", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pstart", 32'(phase_start), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_ftick", 32'(frame_tick), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_busy", 32'(busy), 32'd0);

    // full sequence
    run_frame(4, 16'd1, 1'b0);

    // phase 2 never completes: abort at active-video start
    run_frame(2, 16'd2, 1'b0);
    act();
    chk("abort", 32'(abort), 32'd1);
    chk("abort_ovr", 32'(overrun), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_nodone", 32'(seq_done), 32'd0);
    chk("abort_pidx", 32'(phase_idx), 32'd0);
    cyc();
    chk("abort_1clk", 32'(abort), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    run_frame(4, 16'd3, 1'b1);

    // abort together with clr_overrun: set wins
    blank();
    clr_overrun = 1'b1;
    act();
    chk("set_wins_abort", 32'(abort), 32'd1);
    chk("set_wins_ovr", 32'(overrun), 32'd1);
    cyc();
    clr_overrun = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);

    // paused frames
    do_reset();
    enable = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      blank();
      chk("pause_ftick", 32'(frame_tick), 32'd1);
      cyc();
      chk("pause_busy", 32'(busy), 32'd0);
      chk("pause_pstart", 32'(phase_start), 32'd0);
      cyc();
      chk("pause_pstart2", 32'(phase_start), 32'd0);
      chk("pause_done", 32'(seq_done), 32'd0);
    end
    chk("pause_fcount", 32'(frame_count), 32'd3);

    // last done coincides with active-video start
    enable = 1'b1;
    run_frame(3, 16'd4, 1'b0);
    phase_done = 4'b1000;
    act();
    phase_done = '0;
    chk("race_done", 32'(seq_done), 32'd1);
    chk("race_abort", 32'(abort), 32'd0);
    chk("race_ovr", 32'(overrun), 32'd0);
    chk("race_busy", 32'(busy), 32'd0);

    // asynchronous reset while waiting on phase 1
    run_frame(1, 16'd5, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pstart", 32'(phase_start), 32'd0);
    chk("arst_pidx", 32'(phase_idx), 32'd0);
    chk("arst_fcount", 32'(frame_count), 32'd0);
    chk("arst_abort", 32'(abort), 32'd0);
    reset = 1'b0;
    act();
    chk("post_rst_abort", 32'(abort), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    p_tick  = 1'b1;
    pixel_y = 10'd479;
    cyc();
    p_tick  = 1'b0;
    chk("post_rst_pstart", 32'(phase_start), 32'd0);
    chk("post_rst_ftick", 32'(frame_tick), 32'd0);
    run_frame(4, 16'd1, 1'b0);

    // counter wrap, then a foreign done bit in WAIT
    do_reset();
    enable  = 1'b0;
    p_tick  = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd480;
    repeat (65535) cyc();
    chk("fc_ffff", 32'(frame_count), 32'h0000_ffff);
    enable = 1'b1;
    cyc();
    p_tick  = 1'b0;
    pixel_y = 10'd100;
    chk("fc_wrap", 32'(frame_count), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd1);
    cyc();
    chk("wrap_pstart", 32'(phase_start), 32'd1);
    cyc();
    phase_done = 4'b0010;
    cyc();
    phase_done = '0;
    chk("foreign_busy", 32'(busy), 32'd1);
    chk("foreign_pidx", 32'(phase_idx), 32'd0);
    cyc();
    chk("foreign_pstart", 32'(phase_start), 32'd0);
    phase_done = 4'b0001;
    cyc();
    phase_done = '0;
    cyc();
    chk("next_pstart", 32'(phase_start), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
